chunk_packer: RTL and testbench
===============================

CHUNK_PACKER -- requirements
Module: chunk_packer

Interface
REQ-001 The block SHALL have parameter CHUNK_SIZE, default 64, giving the number of 2x2 RGB888 blocks (96 bits each) per chunk.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port s_block_tdata, input, 96 bits: one 2x2 block of 24-bit pixels.
REQ-005 The block SHALL have port s_block_tvalid, input, 1 bit: a source block is valid.
REQ-006 The block SHALL have port s_block_tready, output, 1 bit: the packer accepts a block.
REQ-007 The block SHALL have port s_block_tlast, input, 1 bit: the block is the final block of its frame.
REQ-008 The block SHALL have port last_input_tdata, output, CHUNK_SIZE*96 bits: the previous chunk of the same frame.
REQ-009 The block SHALL have ports last_input_tvalid (output, 1 bit) and last_input_tready (input, 1 bit): the handshake for last_input_tdata.
REQ-010 The block SHALL have port current_input_tdata, output, CHUNK_SIZE*96 bits: the newest completed chunk.
REQ-011 The block SHALL have ports current_input_tvalid (output, 1 bit) and current_input_tready (input, 1 bit): the handshake for current_input_tdata.

Function
REQ-012 A source beat SHALL be accepted only in cycles where s_block_tvalid and s_block_tready are both 1.
REQ-013 The k-th accepted block of a chunk SHALL occupy bits [k*96 +: 96] of the accumulator, with k starting at 0.
REQ-014 A chunk SHALL complete on the accepted beat where k equals CHUNK_SIZE-1, or where s_block_tlast is 1, whichever comes first; k then returns to 0.
REQ-015 On a short chunk (s_block_tlast before slot CHUNK_SIZE-1), all unwritten slots SHALL be output as zero.
REQ-016 A completed chunk SHALL transfer to the output pair on the completing clock edge if the pair is released (REQ-019), so both tvalids are 1 in the next cycle (latency 1).
REQ-017 On transfer, current_input_tdata SHALL be loaded with the completed chunk, last_input_tdata with the history register, and the history register with the completed chunk.
REQ-018 On a transfer of a chunk that ended with s_block_tlast, the history register SHALL be loaded with zero instead, so the first chunk of each frame has last_input_tdata equal to 0.
REQ-019 The output pair SHALL count as released in a cycle where each channel's tvalid is either already 0 or is being handshaken (tvalid and tready both 1) in that cycle.
REQ-020 Each output channel SHALL drop its own tvalid independently, in the cycle after its own handshake.
REQ-021 Each output channel's tdata SHALL remain stable while its tvalid is 1.
REQ-022 If a chunk completes while the pair is not released, the block SHALL hold it in the accumulator, set a full flag, and drive s_block_tready to 0.
REQ-023 While the full flag is set, the held chunk SHALL transfer on the first edge where the pair is released; s_block_tready SHALL be 1 in the following cycle.
REQ-024 The accumulator SHALL be cleared to zero on every transfer.
REQ-025 When the full flag is clear, s_block_tready SHALL be 1 in every non-reset cycle, including the completing beat's cycle.
REQ-026 s_block_tready SHALL be combinational from the full flag and reset only, and SHALL NOT depend on any tready input.

Reset
REQ-027 While reset is 1, s_block_tready, last_input_tvalid and current_input_tvalid SHALL be 0.
REQ-028 Reset SHALL clear both output tdata registers, the accumulator, the history register, the slot index and the full flag to 0.
REQ-029 A reset asserted mid-chunk or mid-handshake SHALL discard all partial and pending data, and the next frame SHALL start with slot index 0 and zero history.

Verification (CHUNK_SIZE=2, both tready held at 1 unless stated)
REQ-030 Send blocks A,B,C,D with tlast on D -> pair (cur=B:A, last=0), then pair (cur=D:C, last=B:A), each with tvalids 1 exactly one cycle after the completing beat.
REQ-031 Send a single block E with tlast=1 -> cur={96'h0,E}, last=0; the next frame's first chunk F:G -> last=0.
REQ-032 Hold current_input_tready=0 and send 4 blocks -> s_block_tready falls to 0 after the 4th beat; both tdata outputs stay stable; raising tready for one cycle -> the second chunk transfers and s_block_tready returns to 1 the following cycle.
REQ-033 Handshake last_input at cycle t and current_input at cycle t+3 -> the pair counts as released only at t+3; no transfer before that edge.
REQ-034 Assert reset for 1 cycle after 1 accepted block -> all tvalids are 0 and the next 2 blocks X,Y give cur=Y:X, last=0.
REQ-035 Drive s_block_tvalid=1 continuously with both readies at 1 -> one block is accepted per cycle with no bubbles, and a chunk pair is emitted every 2 cycles.

Source files
------------

// File: rtl/chunk_packer_if.sv
// -----------------------------------------------------------------------------
// chunk_packer_if
// Bundles the three handshake channels around the chunk packer:
//   - s_block_*       : incoming stream of 96-bit 2x2 RGB888 blocks
//                       (tdata, tvalid, tlast from the source; tready back)
//   - last_input_*    : previous chunk of the same frame (tdata, tvalid out;
//                       tready in)
//   - current_input_* : newest completed chunk (tdata, tvalid out; tready in)
// Modports:
//   slave  - the packer side (sinks blocks, sources chunks)
//   master - the environment side (sources blocks, sinks chunks)
// Parameter CHUNK_SIZE must match the packer instance it is connected to.
// -----------------------------------------------------------------------------
interface chunk_packer_if #(
   parameter int CHUNK_SIZE = 64
);
   localparam int BLOCK_W = 96;
   localparam int CHUNK_W = CHUNK_SIZE * BLOCK_W;

   logic [BLOCK_W-1:0] s_block_tdata;
   logic               s_block_tvalid;
   logic               s_block_tready;
   logic               s_block_tlast;

   logic [CHUNK_W-1:0] last_input_tdata;
   logic               last_input_tvalid;
   logic               last_input_tready;

   logic [CHUNK_W-1:0] current_input_tdata;
   logic               current_input_tvalid;
   logic               current_input_tready;

   modport slave (
      input  s_block_tdata,
      input  s_block_tvalid,
      input  s_block_tlast,
      output s_block_tready,
      output last_input_tdata,
      output last_input_tvalid,
      input  last_input_tready,
      output current_input_tdata,
      output current_input_tvalid,
      input  current_input_tready
   );

   modport master (
      output s_block_tdata,
      output s_block_tvalid,
      output s_block_tlast,
      input  s_block_tready,
      input  last_input_tdata,
      input  last_input_tvalid,
      output last_input_tready,
      input  current_input_tdata,
      input  current_input_tvalid,
      output current_input_tready
   );
endinterface

// File: rtl/chunk_packer.sv
// -----------------------------------------------------------------------------
// chunk_packer
// Packs a stream of 96-bit 2x2 RGB888 blocks into chunks of CHUNK_SIZE blocks
// and presents each completed chunk together with the previous chunk of the
// same frame on two independently handshaken output channels.
//
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   reset - synchronous, active-high reset
//   bus   - chunk_packer_if.slave: block input stream and the two chunk
//           output channels (last_input_*, current_input_*)
//
// Operation:
//   Block k of a chunk lands in accumulator slot [k*96 +: 96]. A chunk
//   completes on slot CHUNK_SIZE-1 or on tlast, whichever is first; unused
//   slots of a short chunk stay zero. When both output channels are free
//   (idle or handshaking this cycle) the chunk moves to the outputs on the
//   completing edge. Otherwise it is parked in the accumulator, the full flag
//   is raised and the input stalls until the outputs free up.
//   The history register remembers the last chunk of the current frame; it
//   is zeroed after a tlast chunk so a new frame starts with no history.
// -----------------------------------------------------------------------------
module chunk_packer #(
   parameter int CHUNK_SIZE = 64
) (
   input  logic          clk,
   input  logic          reset,
   chunk_packer_if.slave bus
);

   localparam int BLOCK_W = 96;
   localparam int CHUNK_W = CHUNK_SIZE * BLOCK_W;
   localparam int SLOT_W  = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHUNK_SIZE - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [CHUNK_W-1:0] acc_reg,       acc_next;
   logic [CHUNK_W-1:0] hist_reg,      hist_next;
   logic [CHUNK_W-1:0] cur_data_reg,  cur_data_next;
   logic [CHUNK_W-1:0] last_data_reg, last_data_next;
   logic [SLOT_W-1:0]  slot_reg,      slot_next;
   logic               full_reg,      full_next;
   logic               full_tlast_reg, full_tlast_next;
   logic               cur_valid_reg,  cur_valid_next;
   logic               last_valid_reg, last_valid_next;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   logic               s_ready;
   logic               accept;
   logic               complete_beat;
   logic               released;
   logic               transfer;
   logic [CHUNK_W-1:0] merged;
   logic [CHUNK_W-1:0] chunk_data;
   logic               chunk_tlast;

   // Input readiness depends only on the full flag and reset, never on the
   // downstream treadys, so the source sees no combinational path from them.
   assign s_ready = !reset && !full_reg;
   assign accept  = bus.s_block_tvalid && s_ready;

   assign complete_beat = accept && ((slot_reg == LAST_SLOT) || bus.s_block_tlast);

   // Each channel is free if it is idle or being consumed in this cycle.
   assign released = (!last_valid_reg || bus.last_input_tready) &&
                     (!cur_valid_reg  || bus.current_input_tready);

   // Accumulator image with the current beat written into its slot. This is
   // the completed chunk on a completing beat, so the transfer can happen on
   // the same edge without first storing the last block.
   generate
      for (genvar gi = 0; gi < CHUNK_SIZE; gi++) begin : g_slot
         assign merged[gi*BLOCK_W +: BLOCK_W] =
            (accept && (slot_reg == SLOT_W'(gi))) ? bus.s_block_tdata
                                                  : acc_reg[gi*BLOCK_W +: BLOCK_W];
      end
   endgenerate

   // A parked chunk is already complete in the accumulator; while parked the
   // input is stalled, so no beat can compete with it.
   assign chunk_data  = full_reg ? acc_reg        : merged;
   assign chunk_tlast = full_reg ? full_tlast_reg : bus.s_block_tlast;
   assign transfer    = (full_reg || complete_beat) && released;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      acc_next        = acc_reg;
      hist_next       = hist_reg;
      cur_data_next   = cur_data_reg;
      last_data_next  = last_data_reg;
      slot_next       = slot_reg;
      full_next       = full_reg;
      full_tlast_next = full_tlast_reg;
      cur_valid_next  = cur_valid_reg;
      last_valid_next = last_valid_reg;

      if (accept) begin
         slot_next = complete_beat ? '0 : slot_reg + 1'b1;
      end

      if (transfer) begin
         cur_data_next   = chunk_data;
         last_data_next  = hist_reg;
         hist_next       = chunk_tlast ? '0 : chunk_data;
         acc_next        = '0;
         full_next       = 1'b0;
         full_tlast_next = 1'b0;
         cur_valid_next  = 1'b1;
         last_valid_next = 1'b1;
      end else begin
         // Channels retire independently; tdata is left untouched so it
         // stays stable for as long as tvalid is held.
         if (cur_valid_reg && bus.current_input_tready) begin
            cur_valid_next = 1'b0;
         end
         if (last_valid_reg && bus.last_input_tready) begin
            last_valid_next = 1'b0;
         end

         if (complete_beat) begin
            // Outputs still busy: park the finished chunk and stall input.
            acc_next        = merged;
            full_next       = 1'b1;
            full_tlast_next = bus.s_block_tlast;
         end else if (accept) begin
            acc_next = merged;
         end
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_reg        <= '0;
         hist_reg       <= '0;
         cur_data_reg   <= '0;
         last_data_reg  <= '0;
         slot_reg       <= '0;
         full_reg       <= 1'b0;
         full_tlast_reg <= 1'b0;
         cur_valid_reg  <= 1'b0;
         last_valid_reg <= 1'b0;
      end else begin
         acc_reg        <= acc_next;
         hist_reg       <= hist_next;
         cur_data_reg   <= cur_data_next;
         last_data_reg  <= last_data_next;
         slot_reg       <= slot_next;
         full_reg       <= full_next;
         full_tlast_reg <= full_tlast_next;
         cur_valid_reg  <= cur_valid_next;
         last_valid_reg <= last_valid_next;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   // The valids are masked by reset so they drop in the very cycle reset
   // rises, not one edge later.
   assign bus.s_block_tready       = s_ready;
   assign bus.current_input_tdata  = cur_data_reg;
   assign bus.current_input_tvalid = cur_valid_reg && !reset;
   assign bus.last_input_tdata     = last_data_reg;
   assign bus.last_input_tvalid    = last_valid_reg && !reset;

endmodule

// File: tb/tb_chunk_packer.sv
// -----------------------------------------------------------------------------
// tb_chunk_packer
// Directed bench for chunk_packer with CHUNK_SIZE = 2. Each cycle the bench
// drives the inputs shortly after the rising edge and compares all outputs
// at the falling edge against hand-computed values. A table covers the basic
// frame sequences and back-to-back streaming; hand-written sequences cover
// output back-pressure, staggered handshakes and reset mid-chunk.
// -----------------------------------------------------------------------------
module tb_chunk_packer;

   localparam int CS = 2;
   localparam int BW = 96;
   localparam int CW = CS * BW;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   chunk_packer_if #(.CHUNK_SIZE(CS)) bus ();

   chunk_packer #(.CHUNK_SIZE(CS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic          rst;
      logic          vld;
      logic [BW-1:0] dat;
      logic          lst;
      logic          lrdy;
      logic          crdy;
      logic          e_srdy;
      logic          e_cv;
      logic          e_lv;
      logic [CW-1:0] e_cur;
      logic [CW-1:0] e_last;
   } vec_t;

   int pass_cnt  = 0;
   int total_cnt = 0;

   function automatic logic [BW-1:0] blk(input logic [7:0] id);
      return {12{id}};
   endfunction

   function automatic vec_t mkv(input logic rst, input logic vld, input logic [BW-1:0] dat,
                                input logic lst, input logic lrdy, input logic crdy,
                                input logic e_srdy, input logic e_cv, input logic e_lv,
                                input logic [CW-1:0] e_cur, input logic [CW-1:0] e_last);
      vec_t v;
      v.rst = rst; v.vld = vld; v.dat = dat; v.lst = lst; v.lrdy = lrdy; v.crdy = crdy;
      v.e_srdy = e_srdy; v.e_cv = e_cv; v.e_lv = e_lv; v.e_cur = e_cur; v.e_last = e_last;
      return v;
   endfunction

   task automatic chk_bit(input string name, input logic act, input logic exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic chk_data(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One cycle: drive inputs, compare outputs mid-cycle, advance past the edge.
   task automatic run_cycle(input string tag, input vec_t v);
      reset                    = v.rst;
      bus.s_block_tvalid       = v.vld;
      bus.s_block_tdata        = v.dat;
      bus.s_block_tlast        = v.lst;
      bus.last_input_tready    = v.lrdy;
      bus.current_input_tready = v.crdy;
      @(negedge clk);
      chk_bit ({tag, " s_block_tready"},       bus.s_block_tready,       v.e_srdy);
      chk_bit ({tag, " current_input_tvalid"}, bus.current_input_tvalid, v.e_cv);
      chk_bit ({tag, " last_input_tvalid"},    bus.last_input_tvalid,    v.e_lv);
      chk_data({tag, " current_input_tdata"},  bus.current_input_tdata,  v.e_cur);
      chk_data({tag, " last_input_tdata"},     bus.last_input_tdata,     v.e_last);
      $display("%s: srdy=%b cv=%b lv=%b", tag, bus.s_block_tready,
               bus.current_input_tvalid, bus.last_input_tvalid);
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[14];

   logic [BW-1:0] A, B, C, D, E, F, G, H, I, J, K;
   logic [BW-1:0] P0, P1, P2, P3, Q, R, U, V, W, X, Y;
   logic [BW-1:0] Z;
   logic [CW-1:0] N;

   initial begin
      A = blk(8'hA1); B = blk(8'hB2); C = blk(8'hC3); D = blk(8'hD4);
      E = blk(8'hE5); F = blk(8'hF6); G = blk(8'h17); H = blk(8'h28);
      I = blk(8'h39); J = blk(8'h4A); K = blk(8'h5B);
      P0 = blk(8'h60); P1 = blk(8'h61); P2 = blk(8'h62); P3 = blk(8'h63);
      Q = blk(8'h7C); R = blk(8'h8D); U = blk(8'h9E); V = blk(8'hAF);
      W = blk(8'hBE); X = blk(8'hCD); Y = blk(8'hDC);
      Z = '0; N = '0;

      //              rst vld dat lst lrdy crdy  srdy cv lv  cur          last
      vecs[0]  = mkv(1, 0, Z, 0, 1, 1,  0, 0, 0, N,           N);
      vecs[1]  = mkv(0, 1, A, 0, 1, 1,  1, 0, 0, N,           N);
      vecs[2]  = mkv(0, 1, B, 0, 1, 1,  1, 0, 0, N,           N);
      vecs[3]  = mkv(0, 1, C, 0, 1, 1,  1, 1, 1, {B, A},      N);
      vecs[4]  = mkv(0, 1, D, 1, 1, 1,  1, 0, 0, {B, A},      N);
      vecs[5]  = mkv(0, 1, E, 1, 1, 1,  1, 1, 1, {D, C},      {B, A});
      vecs[6]  = mkv(0, 1, G, 0, 1, 1,  1, 1, 1, {Z, E},      N);
      vecs[7]  = mkv(0, 1, F, 0, 1, 1,  1, 0, 0, {Z, E},      N);
      vecs[8]  = mkv(0, 1, H, 0, 1, 1,  1, 1, 1, {F, G},      N);
      vecs[9]  = mkv(0, 1, I, 0, 1, 1,  1, 0, 0, {F, G},      N);
      vecs[10] = mkv(0, 1, J, 0, 1, 1,  1, 1, 1, {I, H},      {F, G});
      vecs[11] = mkv(0, 1, K, 1, 1, 1,  1, 0, 0, {I, H},      {F, G});
      vecs[12] = mkv(0, 0, Z, 0, 1, 1,  1, 1, 1, {K, J},      {I, H});
      vecs[13] = mkv(0, 0, Z, 0, 1, 1,  1, 0, 0, {K, J},      {I, H});

      reset = 1'b1;
      bus.s_block_tvalid = 1'b0;
      bus.s_block_tdata = '0;
      bus.s_block_tlast = 1'b0;
      bus.last_input_tready = 1'b1;
      bus.current_input_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         run_cycle($sformatf("vec%0d", i), vecs[i]);
      end

      // Current channel stalled: second chunk is parked and input stalls.
      run_cycle("bp0",  mkv(0, 1, P0, 0, 1, 0,  1, 0, 0, {K, J},   {I, H}));
      run_cycle("bp1",  mkv(0, 1, P1, 0, 1, 0,  1, 0, 0, {K, J},   {I, H}));
      run_cycle("bp2",  mkv(0, 1, P2, 0, 1, 0,  1, 1, 1, {P1, P0}, N));
      run_cycle("bp3",  mkv(0, 1, P3, 0, 1, 0,  1, 1, 0, {P1, P0}, N));
      run_cycle("bp4",  mkv(0, 1, Q,  0, 1, 0,  0, 1, 0, {P1, P0}, N));
      run_cycle("bp5",  mkv(0, 1, Q,  0, 1, 0,  0, 1, 0, {P1, P0}, N));
      run_cycle("bp6",  mkv(0, 1, Q,  0, 1, 1,  0, 1, 0, {P1, P0}, N));
      run_cycle("bp7",  mkv(0, 0, Z,  0, 0, 0,  1, 1, 1, {P3, P2}, {P1, P0}));
      run_cycle("bp8",  mkv(0, 0, Z,  0, 1, 1,  1, 1, 1, {P3, P2}, {P1, P0}));
      // Q must not have been taken while stalled: R lands in slot 0.
      run_cycle("bp9",  mkv(0, 1, R,  1, 1, 1,  1, 0, 0, {P3, P2}, {P1, P0}));
      run_cycle("bp10", mkv(0, 0, Z,  0, 1, 1,  1, 1, 1, {Z, R},   {P3, P2}));

      // Staggered handshakes: release only once both channels are free.
      run_cycle("st0", mkv(0, 1, A, 0, 0, 0,  1, 0, 0, {Z, R},  {P3, P2}));
      run_cycle("st1", mkv(0, 1, B, 0, 0, 0,  1, 0, 0, {Z, R},  {P3, P2}));
      run_cycle("st2", mkv(0, 1, C, 0, 0, 0,  1, 1, 1, {B, A},  N));
      run_cycle("st3", mkv(0, 1, D, 1, 0, 0,  1, 1, 1, {B, A},  N));
      run_cycle("st4", mkv(0, 0, Z, 0, 1, 0,  0, 1, 1, {B, A},  N));
      run_cycle("st5", mkv(0, 0, Z, 0, 0, 0,  0, 1, 0, {B, A},  N));
      run_cycle("st6", mkv(0, 0, Z, 0, 0, 0,  0, 1, 0, {B, A},  N));
      run_cycle("st7", mkv(0, 0, Z, 0, 0, 1,  0, 1, 0, {B, A},  N));
      run_cycle("st8", mkv(0, 0, Z, 0, 0, 0,  1, 1, 1, {D, C},  {B, A}));
      run_cycle("st9", mkv(0, 0, Z, 0, 1, 1,  1, 1, 1, {D, C},  {B, A}));

      // Reset mid-chunk with both outputs pending.
      run_cycle("rs0", mkv(0, 1, U, 0, 1, 1,  1, 0, 0, {D, C},  {B, A}));
      run_cycle("rs1", mkv(0, 1, V, 0, 1, 1,  1, 0, 0, {D, C},  {B, A}));
      run_cycle("rs2", mkv(0, 1, W, 0, 0, 0,  1, 1, 1, {V, U},  N));
      run_cycle("rs3", mkv(1, 0, Z, 0, 0, 0,  0, 0, 0, {V, U},  N));
      run_cycle("rs4", mkv(0, 1, X, 0, 1, 1,  1, 0, 0, N,       N));
      run_cycle("rs5", mkv(0, 1, Y, 0, 1, 1,  1, 0, 0, N,       N));
      run_cycle("rs6", mkv(0, 0, Z, 0, 1, 1,  1, 1, 1, {Y, X},  N));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
